// File: rtl/array_initializer_mc_if.sv
// Array write-port bundle between the initialiser and the port mux.
// master drives a row write; slave returns ready.
interface array_initializer_mc_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int ROW_WIDTH  = 16,
  parameter int NUM_BLOCKS = 4,
  parameter int NUM_BANKS  = 2
);
  logic                          ready;
  logic                          valid;
  logic [ADDR_WIDTH-1:0]         addr;
  logic [NUM_BANKS*ROW_WIDTH-1:0] data;
  logic [NUM_BANKS-1:0]          wen;
  logic [NUM_BLOCKS-1:0]         wmask;

  modport master (
    input  ready,
    output valid,
    output addr,
    output data,
    output wen,
    output wmask
  );

  modport slave (
    output ready,
    input  valid,
    input  addr,
    input  data,
    input  wen,
    input  wmask
  );
endinterface

// File: rtl/array_initializer_mc.sv
// Multi-bank status/tag array initialiser with range re-init.
// ARRAY_INIT_PATTERN_EN adds i_pattern_mode (address^fill data).
module array_initializer_mc #(
  parameter int ADDR_WIDTH = 7,
  parameter int ROW_WIDTH  = 16,
  parameter int NUM_BLOCKS = 4,
  parameter int NUM_BANKS  = 2,
  parameter logic [ROW_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  gated_clk,
  input  logic                  arst_n,
  array_initializer_mc_if.master bus,
  input  logic                  i_reinit,
  input  logic [ADDR_WIDTH-1:0] i_reinit_base,
  input  logic [ADDR_WIDTH-1:0] i_reinit_last,
  input  logic [NUM_BANKS-1:0]  i_reinit_bank_mask,
`ifdef ARRAY_INIT_PATTERN_EN
  input  logic                  i_pattern_mode,
`endif
  output logic                  o_init_complete,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam int DW = NUM_BANKS * ROW_WIDTH;

  typedef enum logic [1:0] {
    UNINIT = 2'd0,
    BUSY   = 2'd1,
    READY  = 2'd2
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic [ADDR_WIDTH:0]   cnt_d;
  logic [ADDR_WIDTH-1:0] last_q;
  logic [NUM_BANKS-1:0]  mask_q;
  logic                  pat_q;
  logic                  pat_in;
  logic                  valid_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DW-1:0]         data_q;
  logic [NUM_BANKS-1:0]  wen_q;
  logic [NUM_BLOCKS-1:0] wmask_q;
  logic                  done_q;
  logic                  busy_q;
  logic                  err_q;
  logic                  bad_req;
  logic                  at_last;

`ifdef ARRAY_INIT_PATTERN_EN
  assign pat_in = i_pattern_mode;
`else
  assign pat_in = 1'b0;
`endif

  assign cnt_d   = cnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign at_last = (cnt_q == {1'b0, last_q});
  assign bad_req = (i_reinit_last < i_reinit_base) ||
                   (i_reinit_bank_mask == '0);

  function automatic logic [DW-1:0] fill(
    input logic [ADDR_WIDTH-1:0] a,
    input logic                  pat
  );
    logic [ROW_WIDTH-1:0] row;
    row = INIT_VALUE ^ (pat ? ROW_WIDTH'(a) : '0);
    return {NUM_BANKS{row}};
  endfunction

  always_ff @(posedge gated_clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= UNINIT;
      cnt_q   <= '0;
      last_q  <= '0;
      mask_q  <= '1;
      pat_q   <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      wen_q   <= '0;
      wmask_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        UNINIT: begin
          state_q <= BUSY;
          cnt_q   <= '0;
          last_q  <= '1;
          mask_q  <= '1;
          pat_q   <= 1'b0;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
        end
        BUSY: begin
          if (!valid_q) begin
            valid_q <= 1'b1;
            addr_q  <= cnt_q[ADDR_WIDTH-1:0];
            data_q  <= fill(cnt_q[ADDR_WIDTH-1:0], pat_q);
            wen_q   <= mask_q;
            wmask_q <= '1;
          end else if (bus.ready) begin
            if (at_last) begin
              state_q <= READY;
              valid_q <= 1'b0;
              addr_q  <= '0;
              data_q  <= '0;
              wen_q   <= '0;
              wmask_q <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cnt_q  <= cnt_d;
              addr_q <= cnt_d[ADDR_WIDTH-1:0];
              data_q <= fill(cnt_d[ADDR_WIDTH-1:0], pat_q);
            end
          end
        end
        READY: begin
          if (i_reinit) begin
            if (bad_req) begin
              err_q <= 1'b1;
            end else begin
              state_q <= BUSY;
              cnt_q   <= {1'b0, i_reinit_base};
              last_q  <= i_reinit_last;
              mask_q  <= i_reinit_bank_mask;
              pat_q   <= pat_in;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= UNINIT;
          valid_q <= 1'b0;
          addr_q  <= '0;
          data_q  <= '0;
          wen_q   <= '0;
          wmask_q <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.valid       = valid_q;
  assign bus.addr        = addr_q;
  assign bus.data        = data_q;
  assign bus.wen         = wen_q;
  assign bus.wmask       = wmask_q;
  assign o_init_complete = done_q;
  assign o_busy          = busy_q;
  assign o_err           = err_q;

endmodule

// File: tb/tb_array_initializer_mc.sv
// Scoreboard bench for array_initializer_mc: random ready/reinit
// against a range-list model, plus directed edge/timing cases.
module tb_array_initializer_mc;
  localparam int AW = 4;
  localparam int RW = 16;
  localparam int NBK = 4;
  localparam int NB = 2;
  localparam logic [RW-1:0] IV = 16'hA5C3;

  logic          gated_clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          i_reinit = 1'b0;
  logic [AW-1:0] i_base = '0;
  logic [AW-1:0] i_last = '0;
  logic [NB-1:0] i_mask = '0;
  logic          o_done, o_busy, o_err;
`ifdef ARRAY_INIT_PATTERN_EN
  logic          i_pattern_mode = 1'b0;
`endif

  array_initializer_mc_if #(
    .ADDR_WIDTH(AW), .ROW_WIDTH(RW),
    .NUM_BLOCKS(NBK), .NUM_BANKS(NB)
  ) bus ();

  array_initializer_mc #(
    .ADDR_WIDTH(AW), .ROW_WIDTH(RW),
    .NUM_BLOCKS(NBK), .NUM_BANKS(NB),
    .INIT_VALUE(IV)
  ) dut (
    .gated_clk          (gated_clk),
    .arst_n             (arst_n),
    .bus                (bus),
    .i_reinit           (i_reinit),
    .i_reinit_base      (i_base),
    .i_reinit_last      (i_last),
    .i_reinit_bank_mask (i_mask),
`ifdef ARRAY_INIT_PATTERN_EN
    .i_pattern_mode     (i_pattern_mode),
`endif
    .o_init_complete    (o_done),
    .o_busy             (o_busy),
    .o_err              (o_err)
  );

  always #5 gated_clk = ~gated_clk;

  typedef struct {
    logic [AW-1:0]    addr;
    logic [NB-1:0]    wen;
    logic [NB*RW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  rdy_mode = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: every accepted range yields one write per row, in order.
  task automatic push_range(input int b, input int l, input int m);
    for (int a = b; a <= l; a++) begin
      wr_t w;
      w.addr = AW'(a);
      w.wen  = NB'(m);
      w.data = {NB{IV}};
      exp_q.push_back(w);
    end
  endtask

  initial begin
    bus.ready = 1'b1;
    forever begin
      @(posedge gated_clk);
      #1;
      if (rdy_mode == 0) bus.ready = 1'b1;
      else if (rdy_mode == 1) bus.ready = ($urandom % 4) != 0;
    end
  end

  logic          pv = 1'b0, pr = 1'b0;
  logic [AW-1:0] pa;
  logic [NB*RW-1:0] pd;
  logic [NB-1:0] pw;

  always @(negedge gated_clk) begin
    if (!arst_n) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", 64'(bus.valid), 64'd1);
        chk("hold_addr", 64'(bus.addr), 64'(pa));
        chk("hold_data", 64'(bus.data), 64'(pd));
        chk("hold_wen", 64'(bus.wen), 64'(pw));
      end
      if (bus.valid) begin
        chk("wmask", 64'(bus.wmask), 64'hF);
        if (bus.ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0h expected none",
                     bus.addr);
          end else begin
            wr_t w;
            w = exp_q.pop_front();
            chk("wr_addr", 64'(bus.addr), 64'(w.addr));
            chk("wr_wen", 64'(bus.wen), 64'(w.wen));
            chk("wr_data", 64'(bus.data), 64'(w.data));
          end
        end
      end else begin
        chk("idle_zero",
            64'({bus.addr, bus.data, bus.wen, bus.wmask}), 64'd0);
      end
      pv = bus.valid;
      pr = bus.ready;
      pa = bus.addr;
      pd = bus.data;
      pw = bus.wen;
    end
  end

  task automatic tick();
    @(posedge gated_clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (o_done && exp_q.size() == 0) break;
      tick();
    end
    chk("done_timeout", 64'(i < budget), 64'd1);
    chk("ready_state", 64'({o_done, o_busy, bus.valid}), 64'b100);
  endtask

  task automatic req(input int b, input int l, input int m);
    i_reinit = 1'b1;
    i_base = AW'(b);
    i_last = AW'(l);
    i_mask = NB'(m);
    tick();
    i_reinit = 1'b0;
    i_base = AW'($urandom);
    i_last = AW'($urandom);
    i_mask = NB'($urandom);
  endtask

  task automatic check_all_zero(input string nm);
    chk(nm, 64'({bus.valid, bus.addr, bus.data, bus.wen, bus.wmask,
                 o_done, o_busy, o_err}), 64'd0);
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    #1;
    check_all_zero("reset_zero");
    exp_q.delete();
    tick();
    push_range(0, 15, 3);
    arst_n = 1'b1;
  endtask

  initial begin
    int n5;
    int b, l, m;
    logic legal;
    #2;
    check_all_zero("por_zero");
    tick();
    push_range(0, 15, 3);
    arst_n = 1'b1;
    for (int e = 1; e <= 18; e++) begin
      tick();
      if (e == 1) begin
        chk("e1_busy", 64'(o_busy), 64'd1);
        chk("e1_valid", 64'(bus.valid), 64'd0);
      end else if (e <= 17) begin
        chk("sweep_valid", 64'(bus.valid), 64'd1);
        chk("sweep_addr", 64'(bus.addr), 64'(e - 2));
      end else begin
        chk("e18_done", 64'({o_done, o_busy, bus.valid}), 64'b100);
      end
    end
    wait_done(10);

    rdy_mode = 2;
    bus.ready = 1'b1;
    do_reset();
    n5 = 0;
    repeat (40) begin
      tick();
      if (bus.valid && bus.addr == 5) begin
        n5++;
        bus.ready = (n5 >= 4);
      end
    end
    chk("addr5_cycles", 64'(n5), 64'd4);
    wait_done(20);

    rdy_mode = 1;
    push_range(3, 6, 2);
    req(3, 6, 2);
    chk("ri_busy", 64'({o_busy, o_done}), 64'b10);
    wait_done(100);

    req(9, 2, 3);
    chk("bad_range_err", 64'({o_err, o_done, bus.valid}), 64'b110);
    tick();
    chk("err_pulse", 64'({o_err, o_done}), 64'b01);
    req(1, 4, 0);
    chk("bad_mask_err", 64'({o_err, o_busy}), 64'b10);
    wait_done(5);

    push_range(0, 15, 1);
    req(0, 15, 1);
    repeat (3) tick();
    req(1, 2, 3);
    chk("busy_req_no_err", 64'(o_err), 64'd0);
    tick();
    chk("busy_req_no_err2", 64'(o_err), 64'd0);
    wait_done(200);

    push_range(15, 15, 3);
    req(15, 15, 3);
    wait_done(50);

    for (int k = 0; k < 8; k++) begin
      b = $urandom_range(0, 15);
      l = $urandom_range(0, 15);
      m = $urandom_range(0, 3);
      legal = (l >= b) && (m != 0);
      if (legal) push_range(b, l, m);
      req(b, l, m);
      chk("rnd_err", 64'(o_err), 64'(!legal));
      chk("rnd_busy", 64'(o_busy), 64'(legal));
      wait_done(200);
    end

    rdy_mode = 0;
    do_reset();
    begin
      int i;
      for (i = 0; i < 50; i++) begin
        tick();
        if (bus.valid && bus.addr == 7) break;
      end
      chk("reach_addr7", 64'(i < 50), 64'd1);
    end
    arst_n = 1'b0;
    #1;
    check_all_zero("mid_reset_zero");
    exp_q.delete();
    tick();
    push_range(0, 15, 3);
    arst_n = 1'b1;
    tick();
    tick();
    chk("restart_addr0", 64'({bus.valid, bus.addr}), 64'h10);
    wait_done(40);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/array_initializer_mc.md
Name: array_initializer_mc

Overview:
- Parametrised, multi-bank successor to the cache status-array initialiser.
- After reset, sweeps every row of NUM_BANKS status/tag banks in parallel, writing a configurable fill value with valid/ready backpressure from the array port.
- Supports software-requested partial re-initialisation of an address range on a bank subset, e.g. cache invalidate-range.
- Sits between reset/control logic and the array write-port mux; owns the port until o_init_complete.

Parameters:
ADDR_WIDTH, 7, row address width; depth = 2**ADDR_WIDTH
ROW_WIDTH, 16, bits per row per bank
NUM_BLOCKS, 4, write-mask bits per row
NUM_BANKS, 2, banks written in parallel
INIT_VALUE, 0, ROW_WIDTH-bit fill value

Ports:
gated_clk  in  1  clock, already gated upstream
arst_n  in  1  asynchronous active-low reset
i_ready  in  1  array port accepts current write
i_reinit  in  1  re-init request pulse; sampled only in READY
i_reinit_base  in  ADDR_WIDTH  first row of range
i_reinit_last  in  ADDR_WIDTH  last row of range, inclusive
i_reinit_bank_mask  in  NUM_BANKS  banks to re-init
o_addr  out  ADDR_WIDTH  row address
o_data  out  NUM_BANKS*ROW_WIDTH  per-bank write data
o_wen  out  NUM_BANKS  per-bank write enable
o_wmask  out  NUM_BLOCKS  block write mask
o_valid  out  1  write presented
o_init_complete  out  1  high in READY only
o_busy  out  1  high in BUSY
o_err  out  1  one-cycle pulse: rejected request

Behaviour:
- Reset is decided as: arst_n, asynchronous, active-low; clock gated_clk. All outputs and registers are async-cleared to 0. State = UNINIT, counter = 0, bank mask = all ones.
- States:
  - UNINIT → BUSY on the first gated_clk edge with arst_n high. Range is 0..2**ADDR_WIDTH-1, all banks.
  - BUSY → READY when the last-address write is accepted.
  - READY → BUSY on i_reinit with a legal range.
  - READY → READY with o_err=1 for one cycle if i_reinit_last < i_reinit_base, or if i_reinit_bank_mask == 0.
  - Illegal state encoding → UNINIT.
- Outputs are registered. The first o_valid appears on the edge after entering BUSY: edge 2 after reset release for a full sweep, edge 2 after an accepted i_reinit.
- While valid, outputs drive:
  - o_data = INIT_VALUE replicated NUM_BANKS times.
  - o_wen = active bank mask.
  - o_wmask = all ones.
  - o_addr = counter.
- Handshake:
  - A write transfers on an edge with o_valid & i_ready.
  - If i_ready is low, o_addr, o_data, o_wen and o_valid hold stable.
  - With i_ready held high, one write per cycle, no bubbles.
  - o_valid never drops without a transfer.
- Counter is ADDR_WIDTH+1 bits so that last = 2**ADDR_WIDTH-1 does not wrap. The terminal compare is against the registered last address.
- On the edge accepting the final write:
  - o_valid, o_wen and o_busy → 0.
  - o_init_complete → 1.
- When not valid, o_addr, o_data, o_wen and o_wmask are 0.
- Single-row range (base == last) produces exactly one write.
- i_reinit during UNINIT or BUSY is ignored: no o_err, no effect.
- Reinit base, last and mask are captured on acceptance. Later input changes are ignored.
- Reset asserted mid-sweep aborts immediately. After release, a full sweep restarts from address 0.
- o_init_complete drops on the edge an accepted i_reinit enters BUSY. o_busy rises on that same edge.

Optional Feature:
- Macro: ARRAY_INIT_PATTERN_EN.
- When defined, adds input i_pattern_mode (1 bit), sampled at BUSY entry; UNINIT entry samples it as 0.
- With mode 1, each bank's o_data = {ROW_WIDTH bits: address zero-extended or truncated to ROW_WIDTH} XOR INIT_VALUE. This serves array BIST readback.
- When undefined, the port is absent and data is always INIT_VALUE.

Test Plan:
- ADDR_WIDTH=4, i_ready=1 after reset release → 16 writes, addr 0..15 on edges 2..17, o_wen=2'b11, o_init_complete=1 from edge 18.
- Same sweep with i_ready=0 for 3 cycles at addr 5 → addr 5 held stable 4 cycles, total 16 writes, no duplicates or gaps.
- In READY, i_reinit base=3 last=6 mask=2'b10 → writes at 3,4,5,6 with o_wen=2'b10, then READY again.
- In READY, i_reinit base=9 last=2 → o_err pulse 1 cycle, no o_valid, o_init_complete stays 1.
- arst_n low at addr 7 of sweep → all outputs 0 immediately; after release, sweep restarts at addr 0 and completes 16 writes.
- i_reinit during BUSY → ignored, no o_err; base=last=15 in READY → exactly one write at addr 15, counter does not wrap.
